// File: rtl/seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared types, constants and the hex-to-segment decode function used by the
// four-digit seven-segment scan controller.
//   SEG_BLANK   : all segments dark (active-low)
//   ANODE_OFF   : all digits deselected (active-low)
//   NUM_DIGITS  : digits scanned per frame
//   digit_idx_t : digit index
//   seg_t       : {g,f,e,d,c,b,a}, active-low
//   disp_t      : registered anode/segment pair
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] ANODE_OFF  = 4'hF;
  localparam int         NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  // Anode and segment lines always change on the same edge, so they are kept
  // together in one register.
  typedef struct packed {
    logic [3:0] anode;
    seg_t       segment;
  } disp_t;

  // Active-low glyphs for 0-9, A, b, C, d, E, F.
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
// Display-word write channel (valid/ready).
//   wr_valid : master offers wr_data
//   wr_data  : four hex nibbles, [3:0] = digit 0
//   wr_ready : slave shadow buffer is free
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if;

  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/seg_scan_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// seg_decoder
// Combinational hex nibble to active-low seven-segment pattern.
//   nibble_i : hex value 0-F
//   seg_o    : {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan sequencer for a 4-digit seven-segment display.
// Each digit owns a slot of SLOT_TICKS refresh ticks; the first BLANK_TICKS
// ticks are dark to suppress ghosting, followed by a lit window whose length
// is the brightness sampled at slot start. Display words arrive over a
// valid/ready channel into a shadow buffer and become visible only at a frame
// boundary (end of the digit-3 slot).
//   clk        : system clock
//   rstP       : synchronous active-high reset
//   tick       : single-cycle refresh strobe
//   en         : scan enable (0 = dark, counters frozen)
//   brightness : lit ticks per slot
//   wr         : display-word write channel (slave)
//   frame_done : one-cycle pulse at end of the digit-3 slot
//   segment    : {g,f,e,d,c,b,a}, active-low
//   anode      : digit select, active-low
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SLOT_TICKS  = 8,
  parameter int BLANK_TICKS = 1,
  parameter int BRIGHT_W    = 3
) (
  input  logic                clk,
  input  logic                rstP,
  input  logic                tick,
  input  logic                en,
  input  logic [BRIGHT_W-1:0] brightness,
  seg_scan_ctrl_if.slave      wr,
  output logic                frame_done,
  output seg_t                segment,
  output logic [3:0]          anode
);

  localparam int PW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  // Comparison width: wide enough for phase, brightness and BLANK+on_ticks.
  localparam int CW = ((BRIGHT_W > PW) ? BRIGHT_W : PW) + 2;

  localparam logic [PW-1:0] PHASE_LAST = PW'(SLOT_TICKS - 1);
  localparam digit_idx_t    DIGIT_LAST = digit_idx_t'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_C    = CW'(BLANK_TICKS);
  localparam logic [CW-1:0] AVAIL_C    = CW'(SLOT_TICKS - BLANK_TICKS);

  logic [PW-1:0]       phase_q, phase_d;
  digit_idx_t          digit_q, digit_d;
  logic [15:0]         active_q, active_d;
  logic [15:0]         shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  disp_t               disp_q, disp_d;
  logic                frame_done_q, frame_done_d;

  logic                adv;
  logic                slot_wrap;
  logic                frame_end;
  logic                wr_fire;

  logic [CW-1:0]       phase_ext;
  logic [CW-1:0]       bright_ext;
  logic [CW-1:0]       on_ticks;
  logic                lit;

  logic [3:0]          nib_w [NUM_DIGITS];
  logic [3:0]          sel_nib;
  seg_t                dec_seg;

  // The shadow buffer is free whenever nothing is waiting for a frame boundary.
  assign wr.wr_ready = ~pending_q;

  // ---------------------------------------------------------------------------
  // Scan counters and word buffering
  // ---------------------------------------------------------------------------
  always_comb begin
    adv          = tick & en;
    slot_wrap    = adv & (phase_q == PHASE_LAST);
    frame_end    = slot_wrap & (digit_q == DIGIT_LAST);
    wr_fire      = wr.wr_valid & ~pending_q;

    phase_d      = phase_q;
    digit_d      = digit_q;
    bright_d     = bright_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = frame_end;

    if (adv) begin
      if (slot_wrap) begin
        phase_d  = '0;
        digit_d  = digit_q + digit_idx_t'(1);
        // Brightness is latched once per slot so a change never alters the
        // lit window of the slot already in progress.
        bright_d = brightness;
      end else begin
        phase_d  = phase_q + PW'(1);
      end
    end

    // A write can never coincide with the transfer: the channel is not ready
    // while a word is pending, so the two branches are mutually exclusive.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (wr_fire) begin
      shadow_d  = wr.wr_data;
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output pattern, computed from next-state so outputs track the tick that
  // caused them with a single register of latency.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib_w[gi] = active_d[4*gi +: 4];
  end

  assign sel_nib = nib_w[digit_d];

  seg_decoder u_dec (
    .nibble_i (sel_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    phase_ext  = CW'(phase_d);
    bright_ext = CW'(bright_d);
    // The lit window cannot extend past the end of the slot.
    on_ticks   = (bright_ext < AVAIL_C) ? bright_ext : AVAIL_C;
    lit        = en & (phase_ext >= BLANK_C) & (phase_ext < (BLANK_C + on_ticks));

    disp_d.anode   = ANODE_OFF;
    disp_d.segment = SEG_BLANK;
    if (lit) begin
      // One-hot low: at most one digit is ever driven.
      disp_d.anode   = ~(4'b0001 << digit_d);
      disp_d.segment = dec_seg;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstP) begin
      phase_q        <= '0;
      digit_q        <= '0;
      active_q       <= 16'h0000;
      shadow_q       <= 16'h0000;
      pending_q      <= 1'b0;
      bright_q       <= '0;
      disp_q.anode   <= ANODE_OFF;
      disp_q.segment <= SEG_BLANK;
      frame_done_q   <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      digit_q        <= digit_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      bright_q       <= bright_d;
      disp_q         <= disp_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign anode      = disp_q.anode;
  assign segment    = disp_q.segment;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int SLOT  = 8;
  localparam int BLANK = 1;
  localparam int BW    = 3;

  logic          clk = 1'b0;
  logic          rstP = 1'b1;
  logic          tick = 1'b0;
  logic          en = 1'b0;
  logic [BW-1:0] brightness = '0;
  logic          frame_done;
  seg_t          segment;
  logic [3:0]    anode;

  seg_scan_ctrl_if wr_if ();

  seg_scan_ctrl #(
    .SLOT_TICKS  (SLOT),
    .BLANK_TICKS (BLANK),
    .BRIGHT_W    (BW)
  ) dut (
    .clk        (clk),
    .rstP       (rstP),
    .tick       (tick),
    .en         (en),
    .brightness (brightness),
    .wr         (wr_if),
    .frame_done (frame_done),
    .segment    (segment),
    .anode      (anode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  typedef struct {
    logic [15:0] word;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  exp_t       sbq[$];
  vec_t       vecs[4];
  logic [6:0] seg_tab[16];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int tick_cnt = 0;
  int hs_cnt = 0;
  int lit_cnt = 0;
  int bad_seg = 0;
  int rdy_low = 0;
  int fd_last = -1;

  // reference model state
  int          m_phase, m_digit, m_bright;
  logic [15:0] m_active, m_shadow;
  bit          m_pend;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Predicts outputs after the coming edge from the inputs being driven now.
  task automatic model_step(output exp_t e);
    bit adv, wrap, frame;
    int on;
    bit lit;
    if (rstP) begin
      m_phase = 0; m_digit = 0; m_bright = 0;
      m_active = 16'h0; m_shadow = 16'h0; m_pend = 0;
      e.anode = 4'hF; e.seg = 7'h7F; e.fd = 1'b0; e.rdy = 1'b1;
      return;
    end
    adv   = tick && en;
    wrap  = adv && (m_phase == SLOT - 1);
    frame = wrap && (m_digit == 3);
    if (frame && m_pend) begin
      m_active = m_shadow;
      m_pend   = 0;
    end else if (wr_if.wr_valid && !m_pend) begin
      m_shadow = wr_if.wr_data;
      m_pend   = 1;
    end
    if (adv) begin
      if (wrap) begin
        m_phase  = 0;
        m_digit  = (m_digit + 1) % 4;
        m_bright = int'(brightness);
      end else begin
        m_phase = m_phase + 1;
      end
    end
    on  = (m_bright < SLOT - BLANK) ? m_bright : SLOT - BLANK;
    lit = en && (m_phase >= BLANK) && (m_phase < BLANK + on);
    e.fd  = frame;
    e.rdy = !m_pend;
    if (lit) begin
      e.anode = 4'hF & ~(4'b0001 << m_digit);
      e.seg   = seg_tab[(m_active >> (4 * m_digit)) & 16'hF];
    end else begin
      e.anode = 4'hF;
      e.seg   = 7'h7F;
    end
  endtask

  task automatic cycle();
    exp_t e, g;
    tick = (cyc % 2 == 0);
    if (tick) tick_cnt++;
    if (wr_if.wr_valid && wr_if.wr_ready && !rstP) hs_cnt++;
    model_step(e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      g = sbq.pop_front();
      check("anode", anode, g.anode);
      check("segment", segment, g.seg);
      check("frame_done", frame_done, g.fd);
      check("wr_ready", wr_if.wr_ready, g.rdy);
    end
    if (frame_done === 1'b1) fd_last = cyc;
    if (anode !== 4'hF) lit_cnt++;
    if (segment !== 7'h7F && segment !== 7'h40) bad_seg++;
  endtask

  task automatic write(input logic [15:0] d);
    bit ok, acc;
    ok = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    for (int i = 0; i < 400; i++) begin
      acc = wr_if.wr_ready;
      if (!acc) rdy_low++;
      cycle();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    wr_if.wr_valid = 1'b0;
    check("write_accept", ok, 1);
  endtask

  task automatic wait_anode(input string nm, input logic [3:0] tgt, input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (anode === tgt) begin
        ok = 1;
        break;
      end
    end
    check(nm, ok, 1);
  endtask

  task automatic wait_fd(input string nm, input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (frame_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check(nm, ok, 1);
  endtask

  task automatic wait_state(input string nm, input int d, input int p, input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (m_digit == d && m_phase == p) begin
        ok = 1;
        break;
      end
    end
    check(nm, ok, 1);
  endtask

  // Never more than one digit driven.
  always @(negedge clk) begin
    if (!$isunknown(anode)) begin
      n_vec++;
      if ($countones(~anode) > 1) begin
        n_bad++;
        $display("FAIL onehot_anode actual=%0h required=at_most_one_low", anode);
      end
    end
  end

  initial begin
    int hs0, f_a, t0;
    logic [3:0] tgt;
    logic [6:0] req;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{16'hFEDC, {7'h0E, 7'h06, 7'h21, 7'h46}};
    vecs[1] = '{16'hBA98, {7'h03, 7'h08, 7'h10, 7'h00}};
    vecs[2] = '{16'h7654, {7'h78, 7'h02, 7'h12, 7'h19}};
    vecs[3] = '{16'h3210, {7'h30, 7'h24, 7'h79, 7'h40}};
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 16'h0;

    // 1: reset and first write
    rstP = 1'b1;
    repeat (2) cycle();
    check("rst_anode", anode, 4'hF);
    check("rst_segment", segment, 7'h7F);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_ready", wr_if.wr_ready, 1);
    rstP = 1'b0; en = 1'b1; brightness = 3'd7;
    write(16'h1234);
    wait_fd("t1_boundary", 200);
    wait_anode("t1_wait_d0", 4'hE, 100); check("t1_d0", segment, 7'h19);
    wait_anode("t1_wait_d1", 4'hD, 100); check("t1_d1", segment, 7'h30);
    wait_anode("t1_wait_d2", 4'hB, 100); check("t1_d2", segment, 7'h24);
    wait_anode("t1_wait_d3", 4'h7, 100); check("t1_d3", segment, 7'h79);

    // 2: brightness windows over one full frame (64 cycles)
    brightness = 3'd3; repeat (64) cycle(); lit_cnt = 0; repeat (64) cycle();
    check("t2_lit_b3", lit_cnt, 24);
    brightness = 3'd0; repeat (64) cycle(); lit_cnt = 0; repeat (64) cycle();
    check("t2_lit_b0", lit_cnt, 0);
    brightness = 3'd7; repeat (64) cycle(); lit_cnt = 0; repeat (64) cycle();
    check("t2_lit_b7", lit_cnt, 56);
    wait_anode("t2_wait_slot", 4'hE, 100);
    brightness = 3'd2;
    lit_cnt = 0; repeat (15) cycle();
    check("t2_cur_slot_keeps7", lit_cnt, 13);
    lit_cnt = 0; repeat (16) cycle();
    check("t2_next_slot_2", lit_cnt, 4);
    brightness = 3'd7;
    repeat (64) cycle();

    // 3: backpressure
    hs0 = hs_cnt;
    write(16'h5A5A);
    rdy_low = 0;
    write(16'hC3C3);
    check("t3_ready_low_seen", rdy_low > 0, 1);
    check("t3_accept_after_fd", cyc - fd_last, 1);
    check("t3_handshakes", hs_cnt - hs0, 2);
    wait_anode("t3_wait_a", 4'hE, 100); check("t3_a_d0", segment, 7'h08);
    wait_fd("t3_boundary_b", 200);
    wait_anode("t3_wait_b", 4'hE, 100); check("t3_b_d0", segment, 7'h30);

    // 4: enable freeze at digit 2 phase 4 for 20 ticks
    wait_fd("t4_sync", 200);
    f_a = fd_last;
    wait_state("t4_reach_d2p4", 2, 4, 200);
    en = 1'b0;
    t0 = tick_cnt;
    cycle();
    check("t4_dark", anode, 4'hF);
    for (int i = 0; i < 200 && (tick_cnt - t0) < 20; i++) cycle();
    check("t4_freeze_ticks", tick_cnt - t0, 20);
    en = 1'b1;
    cycle();
    check("t4_resume_digit2", anode, 4'hB);
    wait_fd("t4_fd_after", 200);
    check("t4_fd_period", fd_last - f_a, 2 * (4 * SLOT) + 2 * 20);

    // 5: decode sweep, table-driven
    for (int v = 0; v < 4; v++) begin
      write(vecs[v].word);
      wait_fd("t5_boundary", 300);
      for (int d = 0; d < 4; d++) begin
        tgt = 4'hF & ~(4'b0001 << d);
        req = vecs[v].segs[7*d +: 7];
        wait_anode("t5_wait_digit", tgt, 100);
        check($sformatf("t5_w%0h_d%0d", vecs[v].word, d), segment, req);
      end
    end

    // 6: reset mid-frame with a pending word
    wait_fd("t6_sync", 200);
    write(16'h1234);
    check("t6_pending", wr_if.wr_ready, 0);
    wait_state("t6_reach_d1", 1, 2, 200);
    rstP = 1'b1;
    cycle();
    check("t6_rst_anode", anode, 4'hF);
    check("t6_rst_segment", segment, 7'h7F);
    check("t6_rst_frame_done", frame_done, 0);
    check("t6_rst_wr_ready", wr_if.wr_ready, 1);
    rstP = 1'b0;
    bad_seg = 0;
    repeat (3 * 64) cycle();
    check("t6_shadow_discarded", bad_seg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
